// File: rtl/sync_delay_pkg.sv
// Shared types and helpers for the sync delay line: FSM states, default delay,
// and the delay-request clamp used when a new delay is loaded.
package sync_delay_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int DEFAULT_DLY = 4;

    typedef struct packed {
        logic [31:0] value;
        logic        err;
    } clamp_t;

    // Out-of-range requests are pulled to the nearest legal delay and flagged.
    function automatic clamp_t clamp_delay(input logic [31:0] sel, input logic [31:0] max);
        clamp_t r;
        r.value = sel;
        r.err   = 1'b0;
        if (sel == 32'd0) begin
            r.value = 32'd1;
            r.err   = 1'b1;
        end else if (sel > max) begin
            r.value = max;
            r.err   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registered rise/fall strobes on a WIDTH-bit sync bus.
// Latency: one clock, strobes valid together with the registered value they describe.
// Backpressure: none; en=0 forces both strobes low.
module sync_edge_detect #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rise <= '0;
            fall <= '0;
        end else if (en) begin
            rise <= nxt & ~cur;
            fall <= ~nxt & cur;
        end else begin
            rise <= '0;
            fall <= '0;
        end
    end

endmodule

// File: rtl/sync_delay_align.sv
// Programmable delay line re-aligning camera sync flags to the pixel pipeline, with edge strobes.
// Latency: CUR_DELAY EN strobes; OUT is frozen for CUR_DELAY strobes after each LOAD.
// Backpressure: EN gates all motion; optional input inversion under SYNC_DELAY_INV_EN.
module sync_delay_align
    import sync_delay_pkg::*;
#(
    parameter int               WIDTH         = 2,
    parameter int               MAX_DELAY     = 16,
    parameter int               DEFAULT_DELAY = DEFAULT_DLY,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b1}},
    parameter int               DLY_W         = $clog2(MAX_DELAY + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] UIN,
`ifdef SYNC_DELAY_INV_EN
    input  logic [WIDTH-1:0] INV_MASK,
`endif
    input  logic             LOAD,
    input  logic [DLY_W-1:0] DELAY_SEL,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic [DLY_W-1:0] CUR_DELAY,
    output logic             BUSY,
    output logic             ERR
);

    // OUT acts as the final stage, so only MAX_DELAY-1 stages are stored.
    localparam int               STG_N = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;
    localparam logic [DLY_W-1:0] ONE   = DLY_W'(1);

    logic [WIDTH-1:0] uin_n;
    logic [WIDTH-1:0] stage [STG_N];
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] nxt_out;
    logic             run_en;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] cur_q, cur_d;
    logic             err_q, err_d;
    clamp_t           clamp_r;

`ifdef SYNC_DELAY_INV_EN
    assign uin_n = UIN ^ INV_MASK;
`else
    assign uin_n = UIN;
`endif

    assign run_en = EN && (state_q == RUN);

    always_comb begin
        nxt_out = uin_n;
        if (cur_q > ONE) begin
            for (int k = 0; k < STG_N; k++) begin
                if (int'(cur_q) == k + 2) begin
                    nxt_out = stage[k];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STG_N; k++) begin
                stage[k] <= RESET_VAL;
            end
            out_q <= RESET_VAL;
        end else begin
            if (EN) begin
                stage[0] <= uin_n;
                for (int k = 1; k < STG_N; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
            if (run_en) begin
                out_q <= nxt_out;
            end
        end
    end

    // A LOAD always wins, including on the cycle that would have ended SETTLE.
    always_comb begin
        clamp_r = clamp_delay(32'(DELAY_SEL), 32'(MAX_DELAY));
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        err_d   = 1'b0;
        if (LOAD) begin
            cur_d   = DLY_W'(clamp_r.value);
            cnt_d   = '0;
            state_d = SETTLE;
            err_d   = clamp_r.err;
        end else if ((state_q == SETTLE) && EN) begin
            if (cnt_q == cur_q - ONE) begin
                cnt_d   = '0;
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            cur_q   <= DLY_W'(DEFAULT_DELAY);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

    sync_edge_detect #(
        .WIDTH (WIDTH)
    ) u_edge (
        .CLK  (CLK),
        .RST  (RST),
        .en   (run_en),
        .cur  (out_q),
        .nxt  (nxt_out),
        .rise (RISE),
        .fall (FALL)
    );

    assign OUT       = out_q;
    assign CUR_DELAY = cur_q;
    assign BUSY      = (state_q == SETTLE);
    assign ERR       = err_q;

endmodule

// File: tb/tb_sync_delay_align.sv
// Randomised scoreboard bench for sync_delay_align: a history-queue reference model
// predicts every cycle's outputs, a separate monitor pops and compares them.
module tb_sync_delay_align;

    localparam int MAXD = 16;

    typedef struct packed {
        logic [1:0] out;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [4:0] cur;
        logic       busy;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] uin = 2'b11;
    logic       load = 1'b0;
    logic [4:0] sel = 5'd0;
    logic [1:0] inv_mask = 2'b00;
    logic [1:0] dout, rise, fall;
    logic [4:0] cur;
    logic       busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    sync_delay_align dut (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .UIN       (uin),
`ifdef SYNC_DELAY_INV_EN
        .INV_MASK  (inv_mask),
`endif
        .LOAD      (load),
        .DELAY_SEL (sel),
        .OUT       (dout),
        .RISE      (rise),
        .FALL      (fall),
        .CUR_DELAY (cur),
        .BUSY      (busy),
        .ERR       (err)
    );

    // Reference model: hist[n] is the input accepted n EN strobes ago (hist[0] = this strobe).
    logic [1:0] hist[$];
    logic [1:0] m_out;
    int         m_d;
    bit         m_blind;
    int         m_left;
    logic [1:0] m_u, m_new;
    exp_t       e;

    always @(posedge clk) begin
        e = '0;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < MAXD; i++) hist.push_back(2'b11);
            m_out   = 2'b11;
            m_d     = 4;
            m_blind = 0;
            m_left  = 0;
        end else begin
`ifdef SYNC_DELAY_INV_EN
            m_u = uin ^ inv_mask;
`else
            m_u = uin;
`endif
            m_new = m_out;
            if (en) begin
                hist.push_front(m_u);
                void'(hist.pop_back());
                if (!m_blind) begin
                    m_new  = hist[m_d-1];
                    e.rise = m_new & ~m_out;
                    e.fall = ~m_new & m_out;
                end
            end
            if (load) begin
                if (sel == 0) begin
                    m_d = 1; e.err = 1'b1;
                end else if (int'(sel) > MAXD) begin
                    m_d = MAXD; e.err = 1'b1;
                end else begin
                    m_d = int'(sel);
                end
                m_blind = 1;
                m_left  = m_d;
            end else if (m_blind && en) begin
                m_left--;
                if (m_left == 0) m_blind = 0;
            end
            m_out = m_new;
        end
        e.out  = m_out;
        e.cur  = 5'(m_d);
        e.busy = m_blind;
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    exp_t x;
    always @(posedge clk) begin
        #1;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
            n_cmp--;
            x = exp_q.pop_front();
            chk("out",  8'(dout), 8'(x.out));
            chk("rise", 8'(rise), 8'(x.rise));
            chk("fall", 8'(fall), 8'(x.fall));
            chk("cur_delay", 8'(cur), 8'(x.cur));
            chk("busy", 8'(busy), 8'(x.busy));
            chk("err",  8'(err),  8'(x.err));
        end
    end

    task automatic step(input logic e_i, input logic [1:0] u_i, input logic l_i, input logic [4:0] s_i);
        @(negedge clk);
        rst  = 1'b0;
        en   = e_i;
        uin  = u_i;
        load = l_i;
        sel  = s_i;
    endtask

    task automatic run(input int n, input logic [1:0] u_i);
        for (int i = 0; i < n; i++) step(1'b1, u_i, 1'b0, 5'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        // default delay with a falling edge on the upper bit
        run(10, 2'b11);
        run(8, 2'b01);
        // reprogram to 9 and push edges through the blind window and beyond
        step(1'b1, 2'b01, 1'b1, 5'd9);
        run(5, 2'b10);
        run(12, 2'b00);
        run(12, 2'b11);
        // clamp cases
        step(1'b1, 2'b11, 1'b1, 5'd0);
        run(3, 2'b01);
        step(1'b1, 2'b01, 1'b1, 5'd20);
        run(18, 2'b10);
        step(1'b1, 2'b10, 1'b1, 5'd16);
        run(20, 2'b01);
        // EN gating with delay 2
        step(1'b1, 2'b01, 1'b1, 5'd2);
        run(3, 2'b01);
        step(1'b1, 2'b10, 1'b0, 5'd0);
        step(1'b0, 2'b01, 1'b0, 5'd0);
        step(1'b0, 2'b00, 1'b0, 5'd0);
        step(1'b1, 2'b11, 1'b0, 5'd0);
        step(1'b1, 2'b11, 1'b0, 5'd0);
        // LOAD on the final SETTLE count restarts the blind window
        step(1'b1, 2'b00, 1'b1, 5'd3);
        run(2, 2'b01);
        step(1'b1, 2'b10, 1'b1, 5'd3);
        run(6, 2'b00);
        // reset in the middle of SETTLE
        step(1'b1, 2'b00, 1'b1, 5'd7);
        run(2, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(6, 2'b00);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 39) == 0),
                 5'($urandom_range(0, 31)));
            inv_mask = ($urandom_range(0, 199) == 0) ? 2'($urandom) : inv_mask;
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
        end
        step(1'b0, 2'b00, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
